// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// fetch port (instruction reads) and the data port (loads/stores).
// Requests are serialised through IDLE -> I_XFER/D_XFER -> RESP; each memory
// command is held on m_* until m_ack and answered with a one-cycle rsp pulse.
// Optional macro ARB_FAIRNESS_EN adds a data-streak counter that forces a
// fetch grant after MAX_D_STREAK consecutive data grants with a fetch waiting.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  input  logic             i_abort,
  output logic             i_rsp_valid,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_busy,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [3:0]       d_wstrb,
  output logic             d_rsp_valid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_busy,
  output logic             m_req,
  output logic             m_we,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  output logic [3:0]       m_wstrb,
  input  logic             m_ack,
  input  logic [WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, I_XFER, D_XFER, RESP} state_t;

  // The streak counter is 3 bits wide, so the limit must fit in it.
  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 7) begin : g_bad_streak
    $error("MAX_D_STREAK must be in the range 1..7");
  end

  state_t           state_q, state_d;
  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [3:0]       m_wstrb_q, m_wstrb_d;
  logic             i_rsp_valid_q, i_rsp_valid_d;
  logic             d_rsp_valid_q, d_rsp_valid_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             drop_q, drop_d;
  logic             fetch_ok;
  logic             force_fetch;

  // A fetch is only eligible when it is not being flushed this cycle.
  assign fetch_ok = i_req & ~i_abort;

`ifdef ARB_FAIRNESS_EN
  localparam logic [2:0] MaxStreak = 3'(MAX_D_STREAK);

  logic [2:0] d_streak_q, d_streak_d;

  assign force_fetch = (d_streak_q == MaxStreak) & fetch_ok;

  // Count data grants made while a fetch waits; any fetch grant clears it.
  always_comb begin
    d_streak_d = d_streak_q;
    if (state_q == IDLE) begin
      if (force_fetch || (fetch_ok && !d_req)) begin
        d_streak_d = '0;
      end else if (d_req && fetch_ok && d_streak_q != 3'd7) begin
        d_streak_d = d_streak_q + 3'd1;
      end
    end
  end

  // Streak counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_streak_q <= '0;
    end else begin
      d_streak_q <= d_streak_d;
    end
  end
`else
  // Strict data priority: a fetch never overrides a pending data request.
  assign force_fetch = 1'b0;
`endif

  // Arbitration, command hold, response capture and abort tracking.
  always_comb begin
    state_d       = state_q;
    m_req_d       = m_req_q;
    m_we_d        = m_we_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    m_wstrb_d     = m_wstrb_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    drop_d        = drop_q;
    i_rsp_valid_d = 1'b0;
    d_rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !force_fetch) begin
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_wstrb_d = d_we ? d_wstrb : 4'b0000;
          state_d   = D_XFER;
        end else if (fetch_ok) begin
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr & ~WIDTH'(3);
          m_wdata_d = '0;
          m_wstrb_d = 4'b0000;
          drop_d    = 1'b0;
          state_d   = I_XFER;
        end
      end
      I_XFER: begin
        if (i_abort) begin
          drop_d = 1'b1;
        end
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = RESP;
          // An abort coinciding with the ack still discards the response.
          if (!(drop_q || i_abort)) begin
            i_rdata_d     = m_rdata;
            i_rsp_valid_d = 1'b1;
          end
        end
      end
      D_XFER: begin
        if (m_ack) begin
          m_req_d       = 1'b0;
          state_d       = RESP;
          d_rsp_valid_d = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      RESP: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, command and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      m_req_q       <= 1'b0;
      m_we_q        <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      m_wstrb_q     <= 4'b0000;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_req_q       <= m_req_d;
      m_we_q        <= m_we_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_wstrb_q     <= m_wstrb_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      drop_q        <= drop_d;
    end
  end

  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_wstrb     = m_wstrb_q;
  assign i_rsp_valid = i_rsp_valid_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_busy      = i_req & ~i_rsp_valid_q;
  assign d_busy      = d_req & ~d_rsp_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table-driven single transactions, hand
// sequences for collision / fairness / reset-in-flight, then random traffic
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int W    = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0, i_abort = 1'b0;
  logic [W-1:0]  i_addr = '0;
  logic          i_rsp_valid, i_busy;
  logic [W-1:0]  i_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0]  d_addr = '0, d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          d_rsp_valid, d_busy;
  logic [W-1:0]  d_rdata;
  logic          m_req, m_we;
  logic [W-1:0]  m_addr, m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_ack = 1'b0;
  logic [W-1:0]  m_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata), .i_busy(i_busy),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_busy(d_busy),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'h0050_0093;
      64:      return 32'hDEAD_BEEF;
      65:      return 32'hCAFE_F00D;
      128:     return 32'h1122_3344;
      default: return 32'h5EED_0000 ^ (i * 32'h0001_0203);
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Memory macro model: m_ack after cur_wait wait states, or manual drive.
  logic [31:0] mem [256];
  bit          mem_ready = 0;
  bit          mem_en = 1;
  bit          rnd_mode = 0;
  bit          man_ack = 0;
  logic [31:0] man_rdata = '0;
  int          wait_n = 0;
  int          cur_wait = 0;
  int          cnt = 0;
  bit          started = 0;

  always @(posedge clk) begin
    #1;
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      mem_ready = 1;
    end
    if (!mem_en) begin
      m_ack = man_ack; m_rdata = man_rdata; started = 0;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (m_req) begin
      if (!started) begin
        started = 1; cnt = 0;
        cur_wait = rnd_mode ? int'($urandom_range(0, 3)) : wait_n;
      end
      if (cnt == cur_wait) begin
        m_ack   = 1'b1;
        m_rdata = mem[m_addr[9:2]];
        if (m_we) mem[m_addr[9:2]] = merge(mem[m_addr[9:2]], m_wdata, m_wstrb);
        started = 0;
      end else begin
        cnt++;
      end
    end else begin
      started = 0;
    end
  end

  // Reference model: one command in flight at a time, next arbitration two
  // cycles after the completing ack, data-first priority (with optional
  // streak-based override), responses filled from a reference memory image.
  logic [31:0] ref_mem [256];
  bit          ref_ready = 0;
  logic        e_mreq = 0, e_ivld = 0, e_dvld = 0, e_mwe = 0;
  logic [31:0] e_maddr = 0, e_mwdata = 0, e_irdata = 0, e_drdata = 0;
  logic [3:0]  e_mwstrb = 0;
  bit          fl_fetch = 0, fl_drop = 0, f_ok = 0, f_force = 0;
  int          cyc = 0, next_arb = 0, m_idx = 0;
`ifdef ARB_FAIRNESS_EN
  int          streak = 0;
`endif

  always @(posedge clk) begin
    if (!ref_ready) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      ref_ready = 1;
    end
    cyc++;
    e_ivld = 0;
    e_dvld = 0;
    if (!rst) begin
      e_mreq = 0; e_irdata = 0; e_drdata = 0; e_mwe = 0; e_maddr = 0; e_mwstrb = 0;
      next_arb = cyc + 1;
`ifdef ARB_FAIRNESS_EN
      streak = 0;
`endif
    end else if (e_mreq) begin
      if (fl_fetch && i_abort) fl_drop = 1;
      if (m_ack) begin
        e_mreq   = 0;
        next_arb = cyc + 2;
        m_idx    = int'(e_maddr[9:2]);
        if (fl_fetch) begin
          if (!fl_drop) begin e_ivld = 1; e_irdata = ref_mem[m_idx]; end
        end else begin
          e_dvld = 1;
          if (e_mwe) ref_mem[m_idx] = merge(ref_mem[m_idx], e_mwdata, e_mwstrb);
          else       e_drdata = ref_mem[m_idx];
        end
      end
    end else if (cyc >= next_arb) begin
      f_ok    = i_req && !i_abort;
      f_force = 0;
`ifdef ARB_FAIRNESS_EN
      f_force = (streak == MAXS) && f_ok;
`endif
      if (d_req && !f_force) begin
        e_mreq = 1; fl_fetch = 0; e_maddr = d_addr; e_mwe = d_we;
        e_mwdata = d_wdata; e_mwstrb = d_we ? d_wstrb : 4'b0;
`ifdef ARB_FAIRNESS_EN
        if (f_ok && streak < 7) streak++;
`endif
      end else if (f_ok) begin
        e_mreq = 1; fl_fetch = 1; fl_drop = 0; e_maddr = i_addr & ~32'd3;
        e_mwe = 0; e_mwstrb = 0;
`ifdef ARB_FAIRNESS_EN
        streak = 0;
`endif
      end
    end
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic        abort;
    logic [31:0] exp_maddr;
    logic        exp_ivld;
    logic        exp_dvld;
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int k);
    int n;
    string tag;
    tag = $sformatf("v%0d", k);
    wait_n = v.waits;
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
    end else begin
      i_req = 1; i_addr = v.addr;
    end
    @(negedge clk);
    chk({tag, "_grant_mreq"}, 32'(m_req), 32'd1);
    chk({tag, "_maddr"}, m_addr, v.exp_maddr);
    chk({tag, "_mwe"}, 32'(m_we), 32'(v.is_d & v.we));
    chk({tag, "_mwstrb"}, 32'(m_wstrb), 32'(v.we ? v.wstrb : 4'b0));
    if (v.is_d && v.we) chk({tag, "_mwdata"}, m_wdata, v.wdata);
    chk({tag, "_busy"}, 32'(v.is_d ? d_busy : i_busy), 32'd1);
    if (v.abort) i_abort = 1;
    n = 0;
    while (m_req && n < 20) begin
      @(negedge clk);
      i_abort = 0;
      n++;
      if (m_req) begin
        chk({tag, "_hold_maddr"}, m_addr, v.exp_maddr);
        chk({tag, "_hold_mwstrb"}, 32'(m_wstrb), 32'(v.we ? v.wstrb : 4'b0));
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'(v.waits + 1));
    chk({tag, "_ivld"}, 32'(i_rsp_valid), 32'(v.exp_ivld));
    chk({tag, "_dvld"}, 32'(d_rsp_valid), 32'(v.exp_dvld));
    chk({tag, "_irdata"}, i_rdata, v.exp_irdata);
    chk({tag, "_drdata"}, d_rdata, v.exp_drdata);
    i_req = 0; d_req = 0;
    @(negedge clk);
    chk({tag, "_pulse_i"}, 32'(i_rsp_valid), 32'd0);
    chk({tag, "_pulse_d"}, 32'(d_rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gcount;
    int first_i;
    logic prev;

    vecs[0] = '{is_d:0, we:0, addr:32'h10,  wdata:0, wstrb:0, waits:0, abort:0,
                exp_maddr:32'h10,  exp_ivld:1, exp_dvld:0,
                exp_irdata:32'h0050_0093, exp_drdata:32'h0};
    vecs[1] = '{is_d:1, we:0, addr:32'h100, wdata:0, wstrb:0, waits:1, abort:0,
                exp_maddr:32'h100, exp_ivld:0, exp_dvld:1,
                exp_irdata:32'h0050_0093, exp_drdata:32'hDEAD_BEEF};
    vecs[2] = '{is_d:1, we:1, addr:32'h200, wdata:32'hA5A5_A5A5, wstrb:4'b0011, waits:3, abort:0,
                exp_maddr:32'h200, exp_ivld:0, exp_dvld:1,
                exp_irdata:32'h0050_0093, exp_drdata:32'hDEAD_BEEF};
    vecs[3] = '{is_d:1, we:0, addr:32'h200, wdata:0, wstrb:0, waits:0, abort:0,
                exp_maddr:32'h200, exp_ivld:0, exp_dvld:1,
                exp_irdata:32'h0050_0093, exp_drdata:32'h1122_A5A5};
    vecs[4] = '{is_d:0, we:0, addr:32'h107, wdata:0, wstrb:0, waits:2, abort:0,
                exp_maddr:32'h104, exp_ivld:1, exp_dvld:0,
                exp_irdata:32'hCAFE_F00D, exp_drdata:32'h1122_A5A5};
    vecs[5] = '{is_d:0, we:0, addr:32'h10,  wdata:0, wstrb:0, waits:2, abort:1,
                exp_maddr:32'h10,  exp_ivld:0, exp_dvld:0,
                exp_irdata:32'hCAFE_F00D, exp_drdata:32'h1122_A5A5};

    // Reset values, with a fetch request asserted during reset.
    rst = 0; i_req = 1;
    repeat (2) @(negedge clk);
    chk("rst_mreq", 32'(m_req), 0);
    chk("rst_mwe", 32'(m_we), 0);
    chk("rst_mwstrb", 32'(m_wstrb), 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_mwdata", m_wdata, 0);
    chk("rst_ivld", 32'(i_rsp_valid), 0);
    chk("rst_dvld", 32'(d_rsp_valid), 0);
    chk("rst_irdata", i_rdata, 0);
    chk("rst_drdata", d_rdata, 0);
    chk("rst_ibusy", 32'(i_busy), 1);
    chk("rst_dbusy", 32'(d_busy), 0);
    i_req = 0; rst = 1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Collision: data first, fetch in the following arbitration slot.
    wait_n = 0;
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h100;
    @(negedge clk);
    chk("col_first_data", m_addr, 32'h100);
    n = 0;
    while (!d_rsp_valid && n < 20) begin
      chk("col_ibusy_wait", 32'(i_busy), 1);
      @(negedge clk); n++;
    end
    chk("col_dvld", 32'(d_rsp_valid), 1);
    chk("col_drdata", d_rdata, 32'hDEAD_BEEF);
    chk("col_ivld_early", 32'(i_rsp_valid), 0);
    chk("col_ibusy_resp", 32'(i_busy), 1);
    d_req = 0;
    @(negedge clk);
    chk("col_gap_mreq", 32'(m_req), 0);
    chk("col_gap_ibusy", 32'(i_busy), 1);
    @(negedge clk);
    chk("col_second_mreq", 32'(m_req), 1);
    chk("col_second_fetch", m_addr, 32'h10);
    n = 0;
    while (!i_rsp_valid && n < 20) begin
      chk("col_ibusy_fetch", 32'(i_busy), 1);
      @(negedge clk); n++;
    end
    chk("col_ivld", 32'(i_rsp_valid), 1);
    chk("col_irdata", i_rdata, 32'h0050_0093);
    i_req = 0;
    @(negedge clk);

    // Fairness / starvation with data held continuously.
    do_reset();
    wait_n = 0;
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
    gcount = 0; first_i = -1; prev = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_req && !prev) begin
        if (m_addr == 32'h40 && first_i < 0) first_i = gcount;
        gcount++;
      end
      prev = m_req;
      if (i_rsp_valid) i_req = 0;
    end
    d_req = 0; i_req = 0;
    chk("fair_grant_count", 32'(gcount >= 10), 1);
`ifdef ARB_FAIRNESS_EN
    chk("fair_fetch_after_4", 32'(first_i), 32'd4);
`else
    chk("starve_no_fetch", 32'(first_i), 32'hFFFF_FFFF);
`endif
    do_reset();

    // Reset asserted during D_XFER; a late ack must be ignored.
    mem_en = 0; man_ack = 0;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    @(negedge clk);
    chk("rx_grant", 32'(m_req), 1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rx_mreq_async", 32'(m_req), 0);
    chk("rx_maddr_async", m_addr, 0);
    chk("rx_drdata_async", d_rdata, 0);
    d_req = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); man_rdata = 32'h77; man_ack = 1;
    @(negedge clk); man_ack = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rx_late_dvld", 32'(d_rsp_valid), 0);
      chk("rx_late_ivld", 32'(i_rsp_valid), 0);
      chk("rx_late_mreq", 32'(m_req), 0);
      chk("rx_late_drdata", d_rdata, 0);
    end
    mem_en = 1;
    do_reset();

    // Random traffic against the reference model.
    rnd_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("r_mreq", 32'(m_req), 32'(e_mreq));
      if (e_mreq) begin
        chk("r_maddr", m_addr, e_maddr);
        chk("r_mwe", 32'(m_we), 32'(e_mwe));
        chk("r_mwstrb", 32'(m_wstrb), 32'(e_mwstrb));
        if (e_mwe) chk("r_mwdata", m_wdata, e_mwdata);
      end
      chk("r_ivld", 32'(i_rsp_valid), 32'(e_ivld));
      chk("r_dvld", 32'(d_rsp_valid), 32'(e_dvld));
      chk("r_irdata", i_rdata, e_irdata);
      chk("r_drdata", d_rdata, e_drdata);
      chk("r_ibusy", 32'(i_busy), 32'(i_req & ~e_ivld));
      chk("r_dbusy", 32'(d_busy), 32'(d_req & ~e_dvld));
      i_abort = 0;
      if (i_req && i_rsp_valid) begin
        i_req = 0;
      end else if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1; i_addr = 32'($urandom_range(0, 1023));
      end else if (i_req && $urandom_range(0, 11) == 0) begin
        i_abort = 1; i_addr = 32'($urandom_range(0, 1023));
      end
      if (d_req && d_rsp_valid) begin
        d_req = 0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 255)) << 2;
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(0, 15));
      end
    end
    i_req = 0; d_req = 0; i_abort = 0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported unified instruction/data memory between the fetch stage (instruction reads) and the memory stage (loads and stores).
- Sits between the pipeline stages and the memory macro. It serialises requests through a small FSM, holds each transaction until the memory acknowledges it, and returns single-cycle response pulses.
- The hazard unit uses the per-port busy outputs as stall sources for the IF and MEM stages.

## Interface
Parameters:
- WIDTH, 32, address and data width.
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is pending. Used only with fairness compiled in.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high with i_addr stable until i_rsp_valid.
- i_addr  in  WIDTH  fetch byte address; bits [1:0] are ignored.
- i_abort  in  1  pipeline flush; discards the pending or in-flight fetch.
- i_rsp_valid  out  1  one-cycle pulse; i_rdata is valid.
- i_rdata  out  WIDTH  fetched instruction.
- i_busy  out  1  i_req & ~i_rsp_valid; drives the IF stall.
- d_req  in  1  data request; held high with all d_* fields stable until d_rsp_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  WIDTH  data byte address.
- d_wdata  in  WIDTH  store data.
- d_wstrb  in  4  store byte enables.
- d_rsp_valid  out  1  one-cycle pulse; for loads, d_rdata is valid.
- d_rdata  out  WIDTH  load data.
- d_busy  out  1  d_req & ~d_rsp_valid; drives the MEM stall.
- m_req  out  1  memory command valid; held until m_ack.
- m_we  out  1  memory write enable.
- m_addr  out  WIDTH  memory address.
- m_wdata  out  WIDTH  memory write data.
- m_wstrb  out  4  memory byte enables; 0 for reads.
- m_ack  in  1  memory completion, one cycle; m_rdata is valid in the same cycle.
- m_rdata  in  WIDTH  memory read data.

## Operation
FSM states: IDLE, I_XFER, D_XFER, RESP.

- **IDLE**
  - Arbitrates among pending requests; data has priority over fetch.
  - The winner's fields are registered onto the m_* outputs and m_req rises.
  - Next state is I_XFER or D_XFER.
- **I_XFER / D_XFER**
  - m_* are held constant until m_ack.
  - On m_ack: m_rdata is captured into the winner's rdata register, m_req falls, and the state moves to RESP.
- **RESP**
  - The winner's rsp_valid is high for exactly one cycle, then the FSM returns to IDLE.
  - Back-to-back transactions therefore have one IDLE arbitration cycle between them.
- **Abort**
  - i_abort high in IDLE: no fetch is granted that cycle.
  - i_abort high during I_XFER (or in the cycle it is entered): a sticky drop flag is set. The memory transaction still completes, but i_rsp_valid is suppressed and i_rdata is not updated.
  - The flag clears on leaving RESP.
- **Stores**
  - d_rsp_valid pulses on completion.
  - d_rdata keeps its previous value.
- **Register values**
  - d_rdata holds its last value until the next load completes.
  - i_rdata holds its last value until the next fetch completes.
- **Fairness** (see Configuration)
  - A 3-bit saturating counter d_streak increments on each data grant made while i_req is pending.
  - It clears on any fetch grant.
  - When d_streak == MAX_D_STREAK and both requests are pending in IDLE, the fetch wins.

## Timing
- Reset values: state=IDLE; m_req, m_we, m_wstrb, i_rsp_valid, d_rsp_valid, d_streak all 0; m_addr, m_wdata, i_rdata, d_rdata all 0.
- i_busy and d_busy are combinational and may be high during reset while requests are asserted.
- Latency: request high at edge t in IDLE, m_req high after edge t+1. With m_ack in the first possible cycle, rsp_valid is high after edge t+2. Minimum request-to-response is 2 cycles, plus one cycle per memory wait state.
- Throughput: at most one transaction per 3 cycles.
- Reset asserted mid-transfer:
  - All outputs return to reset values immediately (asynchronous).
  - An in-flight m_ack is ignored.
  - The requester must re-issue.
- Simultaneous m_ack and i_abort in I_XFER: the response is dropped.
- A request that deasserts before its response violates the protocol; behaviour is undefined.

## Configuration
- ARB_FAIRNESS_EN defined: the d_streak counter and the forced fetch grant are present.
- Not defined: strict data priority, the counter is absent, and a continuously requesting data port can starve fetch indefinitely.

## Test plan
- Single fetch: i_req=1, i_addr=0x10, memory acks 1 cycle after m_req with 0x00500093.
  - m_req/m_addr=0x10 after edge 1.
  - i_rsp_valid=1 with i_rdata=0x00500093 after edge 2.
- Collision: i_req and d_req (load 0x100, data 0xDEADBEEF) rise together.
  - Data is granted first; d_rsp_valid pulses.
  - The fetch is granted in the next IDLE cycle; i_busy stays high throughout.
- Store: d_we=1, d_addr=0x200, d_wdata=0xA5A5A5A5, d_wstrb=4'b0011, memory 3 wait states.
  - m_* held stable for 3 cycles.
  - d_rsp_valid pulses; d_rdata unchanged.
- Abort: i_abort pulsed one cycle into I_XFER.
  - The memory transaction completes.
  - i_rsp_valid stays 0 and i_rdata is unchanged.
- Fairness with ARB_FAIRNESS_EN: d_req held continuously with i_req pending.
  - Exactly 4 data grants occur, then a fetch grant.
  - Without the macro, no fetch grant occurs in 40 cycles.
- Reset mid-transfer: rst driven low during D_XFER.
  - m_req goes to 0 immediately.
  - After release, the state is IDLE and a late m_ack produces no rsp_valid.
